multi_clk_divider: RTL and testbench

MULTI_CLK_DIVIDER -- requirements
Module: multi_clk_divider

---
 rtl/multi_clk_divider_pkg.sv | 10 +
 rtl/clk_div_channel.sv | 98 +++++++++
 rtl/multi_clk_divider.sv | 45 ++++
 tb/tb_multi_clk_divider.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_clk_divider_pkg.sv
// Shared constants for the multi-channel clock divider: output mode encoding
// and the divisor every channel comes out of reset with.
package multi_clk_divider_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int DEFAULT_DIV = 1000000;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: free-running counter against an applied divisor, with a
// shadow divisor and mode that only take over at a period boundary or while idle.
module clk_div_channel #(
    parameter int CNT_W       = 25,
    parameter int DEFAULT_DIV = multi_clk_divider_pkg::DEFAULT_DIV
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             divided_clk_o,
    output logic             tick_o,
    output logic             pending_o
);
    import multi_clk_divider_pkg::*;

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
    logic             mode_active_q, mode_active_d;
    logic             pending_q, pending_d;
    logic             divided_clk_q, divided_clk_d;
    logic             tick_q, tick_d;
    logic             term_cnt;

    assign term_cnt = en_i && (cnt_q == div_active_q);

    always_comb begin
        cnt_d         = cnt_q;
        div_active_d  = div_active_q;
        div_shadow_d  = div_shadow_q;
        mode_active_d = mode_active_q;
        pending_d     = pending_q;
        divided_clk_d = divided_clk_q;
        tick_d        = 1'b0;

        // The shadow is sampled before this cycle's load lands, so a load that
        // coincides with a boundary waits for the next one and keeps pending set.
        if (term_cnt || !en_i) begin
            div_active_d  = div_shadow_q;
            mode_active_d = mode_i;
            pending_d     = 1'b0;
        end
        if (load_i) begin
            div_shadow_d = load_val_i;
            pending_d    = 1'b1;
        end

        if (!en_i) begin
            cnt_d         = '0;
            divided_clk_d = 1'b0;
        end else if (term_cnt) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (mode_i != mode_active_q) begin
                divided_clk_d = 1'b0;
            end else if (mode_active_q == MODE_TOGGLE) begin
                divided_clk_d = ~divided_clk_q;
            end else begin
                divided_clk_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mode_active_q == MODE_PULSE) begin
                divided_clk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            div_active_q  <= RST_DIV;
            div_shadow_q  <= RST_DIV;
            mode_active_q <= MODE_TOGGLE;
            pending_q     <= 1'b0;
            divided_clk_q <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            div_active_q  <= div_active_d;
            div_shadow_q  <= div_shadow_d;
            mode_active_q <= mode_active_d;
            pending_q     <= pending_d;
            divided_clk_q <= divided_clk_d;
            tick_q        <= tick_d;
        end
    end

    assign divided_clk_o = divided_clk_q;
    assign tick_o        = tick_q;
    assign pending_o     = pending_q;

endmodule

// File: rtl/multi_clk_divider.sv
// NUM_CH independent clock dividers sharing one divisor write port; the top
// only decodes the write channel and gathers the per-channel outputs.
module multi_clk_divider #(
    parameter int   NUM_CH      = 4,
    parameter int   CNT_W       = 25,
    parameter int   DEFAULT_DIV = multi_clk_divider_pkg::DEFAULT_DIV,
    localparam int  LCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              load,
    input  logic [LCH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0]  load_val,
    output logic [NUM_CH-1:0] divided_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] load_hit;

    // An out-of-range load_ch matches no channel and is dropped.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign load_hit[gi] = load && (load_ch == LCH_W'(gi));

            clk_div_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk_in        (clk_in),
                .rst           (rst),
                .en_i          (en[gi]),
                .mode_i        (mode[gi]),
                .load_i        (load_hit[gi]),
                .load_val_i    (load_val),
                .divided_clk_o (divided_clk[gi]),
                .tick_o        (tick[gi]),
                .pending_o     (pending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed scoreboard bench for multi_clk_divider (3 channels, short default divisor).
module tb_multi_clk_divider;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DDIV = 20;

    logic           clk_in;
    logic           rst;
    logic [NCH-1:0] en;
    logic [NCH-1:0] mode;
    logic           load;
    logic [1:0]     load_ch;
    logic [CW-1:0]  load_val;
    logic [NCH-1:0] divided_clk;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;

    multi_clk_divider #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .load_ch     (load_ch),
        .load_val    (load_val),
        .divided_clk (divided_clk),
        .tick        (tick),
        .pending     (pending)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [8:0] mask;
        logic [8:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [8:0] obs;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    assign obs = {pending, tick, divided_clk};

    task automatic exp_all(input int c, input string nm, input logic [8:0] m, input logic [8:0] v);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.mask = m;
        e.val  = v & m;
        sb.push_back(e);
    endtask

    // m/v are {pending, tick, divided_clk} for one channel
    task automatic exp_ch(input int c, input string nm, input int ch, input logic [2:0] m, input logic [2:0] v);
        logic [8:0] mm;
        logic [8:0] vv;
        mm = '0;
        vv = '0;
        mm[ch]     = m[0];
        mm[3+ch]   = m[1];
        mm[6+ch]   = m[2];
        vv[ch]     = v[0];
        vv[3+ch]   = v[1];
        vv[6+ch]   = v[2];
        exp_all(c, nm, mm, vv);
    endtask

    task automatic go(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk_in) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_tests++;
                if (sb[i].cyc < cyc) begin
                    n_fail++;
                    $display("[TB] FAIL %s: expectation for cyc %0d missed (now %0d)", sb[i].name, sb[i].cyc, cyc);
                end else if ((obs & sb[i].mask) !== sb[i].val) begin
                    n_fail++;
                    $display("[TB] FAIL %s cyc=%0d {pend,tick,dclk} got=%b want=%b mask=%b",
                             sb[i].name, cyc, obs & sb[i].mask, sb[i].val, sb[i].mask);
                end else begin
                    $display("[TB] ok   %s cyc=%0d {pend,tick,dclk}=%b", sb[i].name, cyc, obs);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int b;
        rst      = 1'b1;
        en       = '0;
        mode     = '0;
        load     = 1'b0;
        load_ch  = '0;
        load_val = '0;
        #1 rst = 1'b0;
        @(negedge clk_in);

        // Reset state
        b = cyc;
        exp_all(b + 1, "reset_q", 9'h1ff, 9'h000);
        exp_all(b + 2, "reset_q2", 9'h1ff, 9'h000);
        go(b + 2);

        // Toggle mode, default divisor: rise after DDIV+1 cycles, period 2*(DDIV+1)
        rst   = 1'b1;
        en[0] = 1'b1;
        b = cyc;
        exp_ch(b + 20, "tog_pre",    0, 3'b111, 3'b000);
        exp_ch(b + 21, "tog_rise",   0, 3'b111, 3'b011);
        exp_ch(b + 22, "tog_hold",   0, 3'b011, 3'b001);
        exp_ch(b + 41, "tog_high",   0, 3'b001, 3'b001);
        exp_ch(b + 42, "tog_fall",   0, 3'b011, 3'b010);
        exp_ch(b + 63, "tog_period", 0, 3'b001, 3'b001);
        exp_ch(b + 65, "en_pre",     0, 3'b011, 3'b001);
        exp_ch(b + 66, "en_drop",    0, 3'b011, 3'b000);
        go(b + 65);
        en[0] = 1'b0;
        go(b + 66);

        // Pulse mode, ch1 divisor 3: 1 cycle high in every 4
        b = cyc;
        load = 1'b1; load_ch = 2'd1; load_val = 8'd3; mode[1] = 1'b1;
        exp_ch(b + 1,  "pls_pend",  1, 3'b100, 3'b100);
        exp_ch(b + 2,  "pls_apply", 1, 3'b100, 3'b000);
        exp_ch(b + 5,  "pls_idle",  1, 3'b011, 3'b000);
        exp_ch(b + 6,  "pls_hi",    1, 3'b011, 3'b011);
        exp_ch(b + 7,  "pls_lo",    1, 3'b011, 3'b000);
        exp_ch(b + 9,  "pls_lo2",   1, 3'b011, 3'b000);
        exp_ch(b + 10, "pls_hi2",   1, 3'b011, 3'b011);
        go(b + 1); load = 1'b0;
        go(b + 2); en[1] = 1'b1;
        go(b + 11);

        // Reload 9 -> 2 at cnt=4 waits for the cnt=9 boundary
        b = cyc;
        load = 1'b1; load_ch = 2'd0; load_val = 8'd9; mode[0] = 1'b0;
        exp_ch(b + 6,  "rl_before", 0, 3'b101, 3'b000);
        exp_ch(b + 7,  "rl_pend",   0, 3'b101, 3'b100);
        exp_ch(b + 11, "rl_hold",   0, 3'b101, 3'b100);
        exp_ch(b + 12, "rl_bound",  0, 3'b111, 3'b011);
        exp_ch(b + 14, "rl_half",   0, 3'b001, 3'b001);
        exp_ch(b + 15, "rl_fall3",  0, 3'b011, 3'b010);
        exp_ch(b + 18, "rl_rise3",  0, 3'b001, 3'b001);
        go(b + 1); load = 1'b0;
        go(b + 2); en[0] = 1'b1;
        go(b + 6); load = 1'b1; load_ch = 2'd0; load_val = 8'd2;
        go(b + 7); load = 1'b0;
        go(b + 19); en[0] = 1'b0;

        // Load coinciding with terminal count on ch2 (5 -> 7)
        b = cyc;
        load = 1'b1; load_ch = 2'd2; load_val = 8'd5; mode[2] = 1'b0;
        exp_ch(b + 7,  "tc_pre",    2, 3'b101, 3'b000);
        exp_ch(b + 8,  "tc_load",   2, 3'b111, 3'b111);
        exp_ch(b + 13, "tc_old6",   2, 3'b101, 3'b101);
        exp_ch(b + 14, "tc_apply",  2, 3'b111, 3'b010);
        exp_ch(b + 21, "tc_new_lo", 2, 3'b001, 3'b000);
        exp_ch(b + 22, "tc_new_hi", 2, 3'b001, 3'b001);
        exp_ch(b + 29, "tc_hi8",    2, 3'b001, 3'b001);
        exp_ch(b + 30, "tc_lo8",    2, 3'b001, 3'b000);
        go(b + 1); load = 1'b0;
        go(b + 2); en[2] = 1'b1;
        go(b + 7); load = 1'b1; load_ch = 2'd2; load_val = 8'd7;
        go(b + 8); load = 1'b0;
        go(b + 31);

        // Out-of-range load_ch is ignored (ch2 keeps its 8-cycle half-period)
        b = cyc;
        load = 1'b1; load_ch = 2'd3; load_val = 8'd1;
        exp_all(b + 1, "badch_pend",  9'b111_000_000, 9'h000);
        exp_all(b + 2, "badch_pend2", 9'b111_000_000, 9'h000);
        exp_ch(b + 6, "badch_lo",  2, 3'b001, 3'b000);
        exp_ch(b + 7, "badch_hi",  2, 3'b001, 3'b001);
        exp_ch(b + 9, "badch_hi2", 2, 3'b001, 3'b001);
        go(b + 1); load = 1'b0; load_ch = 2'd0;
        go(b + 10); en[2] = 1'b0;

        // Divisor 0 in toggle mode gives clk_in/2, then a mode change at a boundary
        b = cyc;
        load = 1'b1; load_ch = 2'd0; load_val = 8'd0;
        exp_ch(b + 2, "d0_idle", 0, 3'b001, 3'b000);
        exp_ch(b + 3, "d0_hi",   0, 3'b011, 3'b011);
        exp_ch(b + 4, "d0_lo",   0, 3'b011, 3'b010);
        exp_ch(b + 5, "d0_hi2",  0, 3'b001, 3'b001);
        exp_ch(b + 6, "mc_force0", 0, 3'b011, 3'b010);
        exp_ch(b + 7, "mc_pulse1", 0, 3'b011, 3'b011);
        exp_ch(b + 8, "mc_const1", 0, 3'b011, 3'b011);
        go(b + 1); load = 1'b0;
        go(b + 2); en[0] = 1'b1;
        go(b + 5); mode[0] = 1'b1;
        go(b + 9);

        // Asynchronous reset pulse between edges with a pending load on ch1
        b = cyc;
        load = 1'b1; load_ch = 2'd1; load_val = 8'd50;
        exp_ch(b + 1,  "rst_pendset", 1, 3'b100, 3'b100);
        exp_all(b + 2, "rst_async",   9'h1ff, 9'h000);
        exp_ch(b + 21, "rst_cnt_lo",  1, 3'b010, 3'b000);
        exp_ch(b + 22, "rst_defdiv",  1, 3'b111, 3'b010);
        exp_ch(b + 43, "rst_lostld",  1, 3'b111, 3'b011);
        go(b + 1);
        load = 1'b0;
        #1 rst = 1'b0;
        #3 rst = 1'b1;
        go(b + 44);

        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk_in);
        if (sb.size() > 0) begin
            $display("[TB] FAIL drain: %0d expectations never checked", sb.size());
            n_tests += sb.size();
            n_fail  += sb.size();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
